// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// Funct3 access-type constants and the byte-enable generator.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size is carried by funct3[1:0]; the unsigned variants share lanes with
    // their signed counterparts. Anything that is not B/H is a full word.
    function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   byte_en = 4'b0001 << addr_lo;
            2'b01:   byte_en = 4'b0011 << addr_lo;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data aligner: picks the addressed byte/half out of the
// read word and sign- or zero-extends it according to funct3.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (funct3_i)
            F3_B:    ext_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ext_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ext_o = {24'h000000, byte_sel};
            F3_HU:   ext_o = {16'h0000, half_sel};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: one req/ack data-memory transaction per memory
// instruction, pipeline stall while it is outstanding, extended load result
// on ReadData_W.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned H/W
// accesses are not issued and raise MisalignErr; otherwise the low address
// bits are forced to alignment and MisalignErr is tied low.
//
// state  | meaning
// IDLE   | waiting for a memory instruction; issues on the same edge
// ACCESS | DReq held high, waiting for DAck
// DONE   | pipeline released; load result moves to ReadData_W
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_M,
    input  logic              MemWrite_M,
    input  logic [2:0]        Funct3_M,
    input  logic [ADDR_W-1:0] ALUResult_M,
    input  logic [31:0]       WriteData_M,
    output logic              Stall_M,
    output logic [31:0]       ReadData_W,
    output logic              MisalignErr,
    output logic              DReq,
    output logic              DWe,
    output logic [ADDR_W-1:0] DAddr,
    output logic [31:0]       DWData,
    output logic [3:0]        DBe,
    input  logic              DAck,
    input  logic [31:0]       DRData
);

    lsu_state_t        state_q;
    logic              dreq_q;
    logic              dwe_q;
    logic [ADDR_W-1:0] daddr_q;
    logic [31:0]       dwdata_q;
    logic [3:0]        dbe_q;
    logic [31:0]       ldata_q;
    logic [31:0]       rdata_w_q;

    logic              req;
    logic              misalign;
    logic              issue;
    logic [1:0]        addr_lo;
    logic [31:0]       wdata_lanes;
    logic [31:0]       ext_data;

    assign req = MemRead_M | MemWrite_M;

    // Aligned low address bits: H drops bit 0, W (and any wider code) drops both.
    always_comb begin
        case (Funct3_M[1:0])
            2'b00:   addr_lo = ALUResult_M[1:0];
            2'b01:   addr_lo = {ALUResult_M[1], 1'b0};
            default: addr_lo = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = req &
                      (((Funct3_M[1:0] == 2'b01) && ALUResult_M[0]) ||
                       ((Funct3_M[1:0] == 2'b10) && (ALUResult_M[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign issue = (state_q == IDLE) && req && !misalign;

    // Store data replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        case (Funct3_M[1:0])
            2'b00:   wdata_lanes = {4{WriteData_M[7:0]}};
            2'b01:   wdata_lanes = {2{WriteData_M[15:0]}};
            default: wdata_lanes = WriteData_M;
        endcase
    end

    load_extend u_load_extend (
        .rdata_i   (DRData),
        .funct3_i  (Funct3_M),
        .addr_lo_i (addr_lo),
        .ext_o     (ext_data)
    );

    // Sequencer: issue from IDLE, wait for DAck in ACCESS, hand off in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dreq_q    <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            dwdata_q  <= 32'h0;
            dbe_q     <= 4'h0;
            ldata_q   <= 32'h0;
            rdata_w_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q  <= ACCESS;
                        dreq_q   <= 1'b1;
                        dwe_q    <= MemWrite_M;
                        daddr_q  <= {ALUResult_M[ADDR_W-1:2], 2'b00};
                        dwdata_q <= wdata_lanes;
                        dbe_q    <= byte_en(Funct3_M, addr_lo);
                    end
                end
                ACCESS: begin
                    if (DAck) begin
                        state_q <= DONE;
                        dreq_q  <= 1'b0;
                        if (!dwe_q) ldata_q <= ext_data;
                    end
                end
                DONE: begin
                    // The instruction is still present this cycle; returning
                    // to IDLE without issuing keeps it from re-launching.
                    if (!dwe_q) rdata_w_q <= ldata_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // rst_n gates the combinational outputs so nothing escapes while in reset.
    assign Stall_M     = rst_n && (issue || (state_q == ACCESS));
    assign MisalignErr = rst_n && (state_q == IDLE) && misalign;

    assign ReadData_W = rdata_w_q;
    assign DReq       = dreq_q;
    assign DWe        = dwe_q;
    assign DAddr      = daddr_q;
    assign DWData     = dwdata_q;
    assign DBe        = dbe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_M, MemWrite_M;
    logic [2:0]  Funct3_M;
    logic [31:0] ALUResult_M, WriteData_M;
    logic        Stall_M;
    logic [31:0] ReadData_W;
    logic        MisalignErr;
    logic        DReq, DWe;
    logic [31:0] DAddr, DWData;
    logic [3:0]  DBe;
    logic        DAck;
    logic [31:0] DRData;

    int n_chk  = 0;
    int n_pass = 0;

    int          stall_cnt, dreq_cnt;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wd, cap_addr, rd_in_done;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .Funct3_M    (Funct3_M),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .Stall_M     (Stall_M),
        .ReadData_W  (ReadData_W),
        .MisalignErr (MisalignErr),
        .DReq        (DReq),
        .DWe         (DWe),
        .DAddr       (DAddr),
        .DWData      (DWData),
        .DBe         (DBe),
        .DAck        (DAck),
        .DRData      (DRData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; called just after a rising edge (cycle N starts).
    // DAck is raised in the k-th ACCESS cycle. Returns with the request
    // dropped and sampled in cycle N+k+2.
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int k);
        MemRead_M   = rd;
        MemWrite_M  = wr;
        Funct3_M    = f3;
        ALUResult_M = addr;
        WriteData_M = wd;
        stall_cnt   = 0;
        dreq_cnt    = 0;
        @(negedge clk);
        if (Stall_M) stall_cnt++;
        if (DReq) dreq_cnt++;
        for (int c = 1; c <= k + 1; c++) begin
            next_cycle();
            DAck   = (c == k);
            DRData = rdat;
            @(negedge clk);
            if (c == 1) begin
                cap_be   = DBe;
                cap_we   = DWe;
                cap_wd   = DWData;
                cap_addr = DAddr;
            end
            if (c == k + 1) rd_in_done = ReadData_W;
            if (Stall_M) stall_cnt++;
            if (DReq) dreq_cnt++;
        end
        next_cycle();
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        DAck       = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        MemRead_M = 0; MemWrite_M = 0; Funct3_M = 3'b000;
        ALUResult_M = 0; WriteData_M = 0; DAck = 0; DRData = 0;
        #12;
        chk("rst_stall", {31'b0, Stall_M}, 32'h0);
        chk("rst_dreq", {31'b0, DReq}, 32'h0);
        chk("rst_rdata", ReadData_W, 32'h0);
        rst_n = 1'b1;
        next_cycle();

        // LB at 0x1003, ack in first ACCESS cycle
        txn(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        chk("lb_dbe", {28'b0, cap_be}, 32'h8);
        chk("lb_daddr", cap_addr, 32'h0000_1000);
        chk("lb_dwe", {31'b0, cap_we}, 32'h0);
        chk("lb_stall_cycles", stall_cnt, 2);
        chk("lb_dreq_cycles", dreq_cnt, 1);
        chk("lb_rd_held_in_done", rd_in_done, 32'h0);
        chk("lb_rdata", ReadData_W, 32'hFFFF_FF80);
        exp_rd = 32'hFFFF_FF80;

        // LHU at 0x2002 with 4-cycle ACCESS
        next_cycle();
        txn(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 4);
        chk("lhu_dbe", {28'b0, cap_be}, 32'hC);
        chk("lhu_stall_cycles", stall_cnt, 5);
        chk("lhu_dreq_cycles", dreq_cnt, 4);
        chk("lhu_rd_held_in_done", rd_in_done, exp_rd);
        chk("lhu_rdata", ReadData_W, 32'h0000_BEEF);
        exp_rd = 32'h0000_BEEF;

        // SB at 0x0001
        next_cycle();
        txn(0, 1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h1234_5678, 2);
        chk("sb_dwe", {31'b0, cap_we}, 32'h1);
        chk("sb_dbe", {28'b0, cap_be}, 32'h2);
        chk("sb_dwdata", cap_wd, 32'hABAB_ABAB);
        chk("sb_stall_cycles", stall_cnt, 3);
        chk("sb_rdata_kept", ReadData_W, exp_rd);

        // SH at 0x0006
        next_cycle();
        txn(0, 1, 3'b001, 32'h0000_0006, 32'h1234_5678, 32'h0, 1);
        chk("sh_dbe", {28'b0, cap_be}, 32'hC);
        chk("sh_dwdata", cap_wd, 32'h5678_5678);
        chk("sh_daddr", cap_addr, 32'h0000_0004);

        // SW at 0x0100
        next_cycle();
        txn(0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1);
        chk("sw_dbe", {28'b0, cap_be}, 32'hF);
        chk("sw_dwdata", cap_wd, 32'hDEAD_BEEF);
        chk("sw_rdata_kept", ReadData_W, exp_rd);

        // LH signed at 0x0000
        next_cycle();
        txn(1, 0, 3'b001, 32'h0000_0000, 32'h0, 32'h0000_8001, 1);
        chk("lh_dbe", {28'b0, cap_be}, 32'h3);
        chk("lh_rdata", ReadData_W, 32'hFFFF_8001);

        // LBU at 0x0001
        next_cycle();
        txn(1, 0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_9A00, 1);
        chk("lbu_rdata", ReadData_W, 32'h0000_009A);
        exp_rd = 32'h0000_009A;

        // LW at 0x0002
        next_cycle();
`ifdef MISALIGN_TRAP_EN
        MemRead_M = 1; Funct3_M = 3'b010; ALUResult_M = 32'h0000_0002;
        @(negedge clk);
        chk("lw_mis_err", {31'b0, MisalignErr}, 32'h1);
        chk("lw_mis_stall", {31'b0, Stall_M}, 32'h0);
        next_cycle();
        MemRead_M = 0;
        @(negedge clk);
        chk("lw_mis_dreq", {31'b0, DReq}, 32'h0);
        chk("lw_mis_err_gone", {31'b0, MisalignErr}, 32'h0);
        chk("lw_mis_rdata", ReadData_W, exp_rd);
`else
        txn(1, 0, 3'b010, 32'h0000_0002, 32'h0, 32'hCAFE_F00D, 1);
        chk("lw_al_daddr", cap_addr, 32'h0);
        chk("lw_al_dbe", {28'b0, cap_be}, 32'hF);
        chk("lw_al_err", {31'b0, MisalignErr}, 32'h0);
        chk("lw_al_rdata", ReadData_W, 32'hCAFE_F00D);
        exp_rd = 32'hCAFE_F00D;
`endif

        // Spurious DAck in IDLE, then read+write together with DAck present
        next_cycle();
        DAck = 1; DRData = 32'h5555_5555;
        @(negedge clk);
        chk("spur_dreq", {31'b0, DReq}, 32'h0);
        chk("spur_stall", {31'b0, Stall_M}, 32'h0);
        next_cycle();
        txn(1, 1, 3'b000, 32'h0000_0003, 32'h0000_0011, 32'h7777_7777, 2);
        chk("both_dwe", {31'b0, cap_we}, 32'h1);
        chk("both_dbe", {28'b0, cap_be}, 32'h8);
        chk("both_dwdata", cap_wd, 32'h1111_1111);
        chk("both_rdata_kept", ReadData_W, exp_rd);

        // Reset in the second ACCESS cycle of an LW
        next_cycle();
        MemRead_M = 1; Funct3_M = 3'b010; ALUResult_M = 32'h0000_0010;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("mid_dreq_before", {31'b0, DReq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dreq", {31'b0, DReq}, 32'h0);
        chk("mid_rst_stall", {31'b0, Stall_M}, 32'h0);
        chk("mid_rst_rdata", ReadData_W, 32'h0);
        chk("mid_rst_dbe", {28'b0, DBe}, 32'h0);
        next_cycle();
        MemRead_M = 0;
        rst_n = 1'b1;
        next_cycle();
        DAck = 1; DRData = 32'hFFFF_FFFF;
        next_cycle();
        DAck = 0;
        next_cycle();
        @(negedge clk);
        chk("late_ack_dreq", {31'b0, DReq}, 32'h0);
        chk("late_ack_stall", {31'b0, Stall_M}, 32'h0);
        chk("late_ack_rdata", ReadData_W, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the pipelined RV32I core. Takes the M-stage address, store data and access type, runs a req/ack transaction on the data-memory port, stalls the pipeline while the access is outstanding, and delivers an aligned, sign/zero-extended load result as ReadData_W. It feeds the writeback result mux, which selects ReadData_W when ResultSrc_W = 2'b01.

## Interface
- ADDR_W, 32, data-memory address width; only 32 is supported.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemRead_M  in  1  load in M stage; held stable while Stall_M = 1
- MemWrite_M  in  1  store in M stage; takes priority if both MemRead_M and MemWrite_M are high
- Funct3_M  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only
- ALUResult_M  in  32  byte address
- WriteData_M  in  32  store data, right-justified
- Stall_M  out  1  freezes the F/D/E/M stages
- ReadData_W  out  32  extended load result
- MisalignErr  out  1  misaligned-access pulse; tied 0 without MISALIGN_TRAP_EN
- DReq  out  1  memory request
- DWe  out  1  1 = write, 0 = read
- DAddr  out  32  word address, {ALUResult_M[31:2], 2'b00}
- DWData  out  32  store lanes
- DBe  out  4  byte enables
- DAck  in  1  single-cycle completion; DRData is valid with it
- DRData  in  32  read word

## Operation
- FSM states are IDLE, ACCESS and DONE. The state register resets to IDLE.
- **IDLE:** if a request is present (MemRead_M | MemWrite_M) and is not flagged misaligned, Stall_M = 1 combinationally and the FSM goes to ACCESS on the next edge. DReq, DWe, DAddr, DWData and DBe are registered on that same edge and held constant throughout ACCESS.
- **ACCESS:** DReq = 1 and Stall_M = 1.
  - On DAck for a load, the extended DRData is captured into an internal ldata register; next state is DONE.
  - On DAck for a store, next state is DONE.
  - DReq deasserts on the edge that leaves ACCESS.
- **DONE:** Stall_M = 0, so the pipeline advances on this edge. On a load, ReadData_W <= ldata. Next state is IDLE.
  - No new access is issued from DONE. This prevents the still-present instruction from re-issuing.
- **Byte lanes:**
  - B: DBe = 0001 << addr[1:0]; DWData replicates byte [7:0] to all four lanes.
  - H: DBe = 0011 << addr[1:0]; DWData replicates half [15:0] to both halves.
  - W: DBe = 1111.
  - Reads drive DBe the same way.
- **Load extension:** select the byte at addr[1:0] or the half at addr[1], then sign-extend for 000/001 and zero-extend for 100/101. Any other Funct3_M on a load returns the full word.
- **ReadData_W updates:** only on load completion; it holds otherwise.
- **Boundary conditions:**
  - DAck outside ACCESS is ignored.
  - DAck may arrive in the first ACCESS cycle.
  - There is no timeout; ACCESS waits indefinitely.
  - rst_n low at any time, including mid-ACCESS, forces state = IDLE and DReq = 0. ReadData_W, ldata and all D* outputs return to 0, and Stall_M = 0 while in reset.

## Timing
- A request is seen in cycle N.
- Stall_M is high in cycle N and stays high through the last ACCESS cycle.
- DReq is high from N+1 until the DAck cycle.
- With DAck at N+k (k ≥ 1), DONE occurs in N+k+1 and ReadData_W is valid from N+k+2.
- Minimum stall is 2 cycles.
- Back-to-back memory instructions each incur the full sequence; there is no pipelining of requests.
- MisalignErr is combinational in IDLE and lasts a single cycle, because the pipeline advances (Stall_M = 0).

## Configuration
- **MISALIGN_TRAP_EN defined:**
  - Misaligned means H with addr[0] = 1, or W with addr[1:0] ≠ 0.
  - A misaligned access is not issued: no DReq, Stall_M stays 0, ReadData_W is unchanged, and MisalignErr = 1 in that IDLE cycle.
- **MISALIGN_TRAP_EN undefined:**
  - Low address bits are forced to alignment: addr[0] is ignored for H, and addr[1:0] are ignored for W.
  - MisalignErr is tied to 0.

## Structure
- lsu_pkg holds:
  - the state enum lsu_state_t (IDLE, ACCESS, DONE);
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the function byte_en(funct3, addr_lo) returning 4 bits.
- Sub-module load_extend is combinational: DRData, Funct3_M and addr[1:0] in, 32-bit extended word out. It is instantiated once, ahead of ldata.

## Test plan
- LB at addr 0x1003, DRData 0x80FF_1234, DAck at N+1 -> DBe 1000, Stall_M high N..N+1, ReadData_W = 0xFFFF_FF80 at N+3.
- LHU at addr 0x2002, DRData 0xBEEF_0000, DAck after 4 wait cycles -> DBe 1100, Stall_M high for 5 cycles, ReadData_W = 0x0000_BEEF.
- SB at addr 0x0001, WriteData_M 0x0000_00AB -> DWe 1, DBe 0010, DWData 0xABAB_ABAB, ReadData_W unchanged.
- LW at 0x0002:
  - with MISALIGN_TRAP_EN -> MisalignErr 1 for one cycle, no DReq, Stall_M 0;
  - without it -> DAddr 0x0000_0000, DBe 1111.
- rst_n low in the 2nd ACCESS cycle of an LW -> DReq 0 and Stall_M 0 immediately. After release the FSM is in IDLE, and a late DAck is ignored with ReadData_W = 0.
- Spurious DAck while IDLE, plus MemRead_M and MemWrite_M both high -> the spurious DAck is ignored and a store is issued (DWe 1).
